// File: rtl/product_accumulator_pkg.sv
// Shared widths and FSM encoding for the multiplier/accumulator datapath.
package product_accumulator_pkg;
    localparam int PROD_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int CNT_W_DEF  = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
endpackage

// File: rtl/product_accumulator_sat_add.sv
// Combinational saturating add: ACC_W accumulator plus zero-extended PROD_W operand.
module sat_add #(
    parameter int ACC_W  = 16,
    parameter int PROD_W = 8
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] operand,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);
    logic [ACC_W:0] wide;

    assign wide  = {1'b0, acc} + (ACC_W + 1)'(operand);
    assign carry = wide[ACC_W];
    // Clamp to all-ones on carry-out so the sum never wraps.
    assign sum   = carry ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
endmodule

// File: rtl/product_accumulator.sv
// Accumulates a programmed number of multiplier products into a saturating sum
// and hands the result downstream with a valid/ready handshake.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_ovf,
    output logic [1:0]        state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; ready/valid here are decoded from state only, never from the peer.
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [ACC_W-1:0] sum;
    logic             carry;

    sat_add #(
        .ACC_W (ACC_W),
        .PROD_W(PROD_W)
    ) u_sat_add (
        .acc    (out_acc),
        .operand(in_prod),
        .sum    (sum),
        .carry  (carry)
    );

    assign cnt_inc   = out_cnt + CNT_W'(1);
    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            len_q   <= '0;
            out_acc <= '0;
            out_cnt <= '0;
            out_ovf <= 1'b0;
        end else if (clear) begin
            state   <= ST_IDLE;
            out_acc <= '0;
            out_cnt <= '0;
            out_ovf <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        out_acc <= '0;
                        out_cnt <= '0;
                        out_ovf <= 1'b0;
                        len_q   <= len;
                        state   <= (len != '0) ? ST_ACCUM : ST_DONE;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        out_acc <= sum;
                        out_cnt <= cnt_inc;
                        out_ovf <= out_ovf | carry;
                        if (cnt_inc == len_q) state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: 16-bit and 9-bit accumulator instances
// share stimulus and are each checked against a true-sum model every cycle.
module tb_product_accumulator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       start = 1'b0;
    logic [3:0] len = '0;
    logic       in_valid = 1'b0;
    logic [7:0] in_prod = '0;
    logic       out_ready = 1'b0;

    logic        in_ready16, out_valid16, out_ovf16;
    logic [15:0] out_acc16;
    logic [3:0]  out_cnt16;
    logic [1:0]  state16;
    logic        in_ready9, out_valid9, out_ovf9;
    logic [8:0]  out_acc9;
    logic [3:0]  out_cnt9;
    logic [1:0]  state9;

    int checks = 0;
    int failures = 0;
    bit checking = 1'b0;

    // model: phase 0 idle, 1 collecting, 2 result held
    int ph = 0;
    int true_sum = 0;
    int m_cnt = 0;
    int m_len = 0;

    product_accumulator #(.PROD_W(8), .ACC_W(16), .CNT_W(4)) dut16 (
        .clk(clk), .rst(rst), .clear(clear), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready16), .in_prod(in_prod),
        .out_valid(out_valid16), .out_ready(out_ready), .out_acc(out_acc16),
        .out_cnt(out_cnt16), .out_ovf(out_ovf16), .state(state16)
    );

    product_accumulator #(.PROD_W(8), .ACC_W(9), .CNT_W(4)) dut9 (
        .clk(clk), .rst(rst), .clear(clear), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready9), .in_prod(in_prod),
        .out_valid(out_valid9), .out_ready(out_ready), .out_acc(out_acc9),
        .out_cnt(out_cnt9), .out_ovf(out_ovf9), .state(state9)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int s, input int max_v);
        return (s > max_v) ? max_v : s;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            ph = 0; true_sum = 0; m_cnt = 0; m_len = 0;
        end else if (clear) begin
            ph = 0; true_sum = 0; m_cnt = 0;
        end else if (ph == 0) begin
            if (start) begin
                true_sum = 0; m_cnt = 0; m_len = int'(len);
                ph = (len != 0) ? 1 : 2;
            end
        end else if (ph == 1) begin
            if (in_valid) begin
                true_sum += int'(in_prod);
                m_cnt++;
                if (m_cnt == m_len) ph = 2;
            end
        end else if (out_ready) begin
            ph = 0;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("in_ready16", 32'(in_ready16), 32'(ph == 1));
            check("out_valid16", 32'(out_valid16), 32'(ph == 2));
            check("in_ready9", 32'(in_ready9), 32'(ph == 1));
            check("out_valid9", 32'(out_valid9), 32'(ph == 2));
            if (ph == 2) begin
                check("out_acc16", 32'(out_acc16), 32'(sat(true_sum, 65535)));
                check("out_ovf16", 32'(out_ovf16), 32'(true_sum > 65535));
                check("out_cnt16", 32'(out_cnt16), 32'(m_cnt));
                check("out_acc9", 32'(out_acc9), 32'(sat(true_sum, 511)));
                check("out_ovf9", 32'(out_ovf9), 32'(true_sum > 511));
                check("out_cnt9", 32'(out_cnt9), 32'(m_cnt));
            end
        end
    end

    task automatic run_products(input int n, input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
        logic [7:0] ps[3];
        ps[0] = p0; ps[1] = p1; ps[2] = p2;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_prod = ps[i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic begin_run(input logic [3:0] l);
        start = 1'b1;
        len = l;
        tick();
        start = 1'b0;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq5[4];
        seq5[0] = 8'd10; seq5[1] = 8'd20; seq5[2] = 8'd30; seq5[3] = 8'd40;

        // 1: reset
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready16), 32'd0);
        check("rst_out_valid", 32'(out_valid16), 32'd0);
        check("rst_out_acc", 32'(out_acc16), 32'd0);
        check("rst_out_cnt", 32'(out_cnt16), 32'd0);
        check("rst_out_acc9", 32'(out_acc9), 32'd0);
        checking = 1'b1;
        tick();

        // 2: 225+15+6
        begin_run(4'd3);
        run_products(3, 8'd225, 8'd15, 8'd6);
        check("t2_valid", 32'(out_valid16), 32'd1);
        check("t2_acc", 32'(out_acc16), 32'd246);
        check("t2_cnt", 32'(out_cnt16), 32'd3);
        check("t2_ovf", 32'(out_ovf16), 32'd0);
        take_result();
        check("t2_idle", 32'(out_valid16), 32'd0);

        // 3: saturation on the 9-bit instance only
        begin_run(4'd3);
        run_products(3, 8'd225, 8'd225, 8'd225);
        check("t3_acc9", 32'(out_acc9), 32'd511);
        check("t3_ovf9", 32'(out_ovf9), 32'd1);
        check("t3_acc16", 32'(out_acc16), 32'd675);
        check("t3_ovf16", 32'(out_ovf16), 32'd0);
        take_result();

        // 4: zero-length run; product offered but never taken
        in_valid = 1'b1;
        in_prod = 8'd77;
        begin_run(4'd0);
        check("t4_valid", 32'(out_valid16), 32'd1);
        check("t4_in_ready", 32'(in_ready16), 32'd0);
        check("t4_acc", 32'(out_acc16), 32'd0);
        check("t4_cnt", 32'(out_cnt16), 32'd0);
        in_valid = 1'b0;
        take_result();

        // 5: gapped input, stalled result, start ignored in DONE
        begin_run(4'd4);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_prod = seq5[i];
            tick();
            in_valid = 1'b0;
            in_prod = 8'd99;
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0);
            len = 4'd2;
            tick();
            check("t5_hold_acc", 32'(out_acc16), 32'd100);
            check("t5_hold_cnt", 32'(out_cnt16), 32'd4);
            check("t5_hold_valid", 32'(out_valid16), 32'd1);
        end
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        check("t5_no_restart", 32'(in_ready16), 32'd0);
        check("t5_idle", 32'(out_valid16), 32'd0);

        // 6: clear mid-run drops the offered product, then a fresh run
        begin_run(4'd5);
        run_products(2, 8'd3, 8'd4, 8'd0);
        clear = 1'b1;
        in_valid = 1'b1;
        in_prod = 8'd50;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        check("t6_clr_ready", 32'(in_ready16), 32'd0);
        check("t6_clr_acc", 32'(out_acc16), 32'd0);
        begin_run(4'd1);
        run_products(1, 8'd9, 8'd0, 8'd0);
        check("t6_acc", 32'(out_acc16), 32'd9);
        check("t6_cnt", 32'(out_cnt16), 32'd1);
        check("t6_ovf", 32'(out_ovf16), 32'd0);
        take_result();

        // reset mid-run behaves like clear
        begin_run(4'd2);
        run_products(1, 8'd5, 8'd0, 8'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_ready", 32'(in_ready16), 32'd0);
        check("rst_mid_acc", 32'(out_acc16), 32'd0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
